spi_sram_arbiter: RTL

SPI_SRAM_ARBITER -- requirements
Module: spi_sram_arbiter

---
 rtl/spi_sram_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spi_sram_arbiter.sv
// spi_sram_arbiter
// Two-port arbiter that serialises SRAM transactions onto a single SPI
// master. Only one transaction is outstanding at a time. The SPI master is
// held idle (spi_req=1) except while a transaction is running. A run that
// sees no spi_valid within TIMEOUT cycles is aborted and reported with err.
//
// Ports
//   clk, rst_n                 system clock, async active-low reset
//   pN_valid/addr/wdata/mask/write   requester N transaction fields
//   pN_ready                   request accepted this cycle (combinational)
//   pN_done                    one-cycle completion pulse to the owner
//   err                        valid with pN_done, 1 = aborted by timeout
//   rdata                      read data, valid with pN_done on reads
//   spi_req                    1 = hold SPI master idle, 0 = run
//   spi_addr/wdata/mask/write  registered transaction fields to SPI master
//   spi_valid, spi_rdata       SPI master completion and read data
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | SPI master held idle; accept one request via round robin
// ST_RUN     | transaction in flight; wait for spi_valid or timeout
// ST_RELEASE | SPI master held idle for RELEASE cycles before next grant

module spi_sram_arbiter #(
   parameter int TIMEOUT = 128,
   parameter int RELEASE = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_valid,
   input  logic [23:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [1:0]  p0_mask,
   input  logic        p0_write,
   output logic        p0_ready,
   output logic        p0_done,
   input  logic        p1_valid,
   input  logic [23:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [1:0]  p1_mask,
   input  logic        p1_write,
   output logic        p1_ready,
   output logic        p1_done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        spi_req,
   output logic [23:0] spi_addr,
   output logic [31:0] spi_wdata,
   output logic [1:0]  spi_mask,
   output logic        spi_write,
   input  logic        spi_valid,
   input  logic [31:0] spi_rdata
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(RELEASE + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] rel_q, rel_d;
   logic [23:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [1:0]    mask_q, mask_d;
   logic          write_q, write_d;
   logic          owner_q, owner_d;
   logic          last_grant_q, last_grant_d;
   logic [1:0]    done_q, done_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;

   logic grant;
   logic accept;

   // Tie goes to the port that did not win last time; a lone requester wins.
   always_comb begin
      if (p0_valid && p1_valid) grant = ~last_grant_q;
      else                      grant = p1_valid;
   end

   assign accept   = (state_q == ST_IDLE) && (p0_valid || p1_valid);
   // Gated by rst_n so ready is low throughout reset even though the
   // state register already reads IDLE.
   assign p0_ready = rst_n & accept & ~grant;
   assign p1_ready = rst_n & accept & grant;

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      rel_d        = rel_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mask_d       = mask_q;
      write_d      = write_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      done_d       = 2'b00;
      err_d        = err_q;
      rdata_d      = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d       = grant ? p1_addr  : p0_addr;
               wdata_d      = grant ? p1_wdata : p0_wdata;
               mask_d       = grant ? p1_mask  : p0_mask;
               write_d      = grant ? p1_write : p0_write;
               owner_d      = grant;
               last_grant_d = grant;
               timer_d      = '0;
               state_d      = ST_RUN;
            end
         end
         ST_RUN: begin
            // spi_valid takes priority over a timeout landing on the same cycle.
            if (spi_valid) begin
               if (!write_q) rdata_d = spi_rdata;
               err_d            = 1'b0;
               done_d[owner_q]  = 1'b1;
               rel_d            = '0;
               state_d          = ST_RELEASE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_d            = 1'b1;
               rdata_d          = '0;
               done_d[owner_q]  = 1'b1;
               rel_d            = '0;
               state_d          = ST_RELEASE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_RELEASE: begin
            if (rel_q == RW'(RELEASE - 1)) state_d = ST_IDLE;
            else                           rel_d   = rel_q + RW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         rel_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mask_q       <= '0;
         write_q      <= 1'b0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         done_q       <= 2'b00;
         err_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         rel_q        <= rel_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mask_q       <= mask_d;
         write_q      <= write_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         done_q       <= done_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
      end
   end

   assign spi_req   = (state_q != ST_RUN);
   assign spi_addr  = addr_q;
   assign spi_wdata = wdata_q;
   assign spi_mask  = mask_q;
   assign spi_write = write_q;
   assign p0_done   = done_q[0];
   assign p1_done   = done_q[1];
   assign err       = err_q;
   assign rdata     = rdata_q;

endmodule
